soc_bus: RTL and testbench

Parametrised memory-mapped interconnect between the `processor` master port and `NSLAVES` slave devices (RAM, LEDs, UART, timers), replacing the single direct processor-to-memory connection in `soc_top`. It decodes the address into a slave window and registers the request toward that slave. It waits on a per-slave ready handshake, with a timeout, and returns read data plus a completion pulse to the master. Unmapped, timed-out and overrun accesses are reported in a sticky error register.

---
 rtl/soc_bus_pkg.sv | 22 ++
 rtl/soc_addr_decode.sv | 22 ++
 rtl/soc_bus.sv | 171 +++++++++++++++++
 tb/tb_soc_bus.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_bus_pkg.sv
// Shared definitions for the soc_bus interconnect: FSM encoding, error flag
// positions, the default error read word and the default slave map.
package soc_bus_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } bus_state_e;

  localparam int unsigned ErrTimeout  = 0;
  localparam int unsigned ErrUnmapped = 1;
  localparam int unsigned ErrOverrun  = 2;

  localparam logic [31:0] ErrWordDefault = 32'hDEAD_BEEF;

  localparam int unsigned SlvRam   = 0;
  localparam int unsigned SlvLed   = 1;
  localparam int unsigned SlvUart  = 2;
  localparam int unsigned SlvTimer = 3;

endpackage

// File: rtl/soc_addr_decode.sv
// Combinational address decoder: extracts the slave index from the select
// field and flags the address as mapped when all bits above it are zero.
module soc_addr_decode #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NSLAVES = 4,
  parameter int unsigned SEL_LSB = 22
) (
  input  logic [XLEN-1:0]                                  addr_i,
  output logic [((NSLAVES > 1) ? $clog2(NSLAVES) : 1)-1:0] idx_o,
  output logic                                             mapped_o
);

  localparam int unsigned SelW = (NSLAVES > 1) ? $clog2(NSLAVES) : 0;
  localparam int unsigned IdxW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

  always_comb begin
    // A single slave has no select field; its index is always zero.
    idx_o    = (NSLAVES > 1) ? IdxW'(addr_i >> SEL_LSB) : '0;
    mapped_o = ((addr_i >> (SEL_LSB + SelW)) == '0);
  end

endmodule

// File: rtl/soc_bus.sv
// Memory-mapped interconnect: decodes the master address into a slave window,
// registers the request, waits for that slave's ready (with timeout) and
// returns data plus a one-cycle completion pulse. Errors are sticky.
module soc_bus
  import soc_bus_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NSLAVES  = 4,
  parameter int unsigned     SEL_LSB  = 22,
  parameter int unsigned     TIMEOUT  = 15,
  parameter logic [XLEN-1:0] ERR_WORD = XLEN'(ErrWordDefault)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [XLEN-1:0]         mem_addr,
  input  logic                    mem_rstrb,
  input  logic [XLEN-1:0]         mem_wdata,
  input  logic [3:0]              mem_wmask,
  output logic [XLEN-1:0]         mem_rdata,
  output logic                    mem_ready,
  output logic                    mem_busy,
  output logic [NSLAVES-1:0]      s_sel,
  output logic [XLEN-1:0]         s_addr,
  output logic [XLEN-1:0]         s_wdata,
  output logic [3:0]              s_wmask,
  output logic                    s_rstrb,
  input  logic [NSLAVES*XLEN-1:0] s_rdata,
  input  logic [NSLAVES-1:0]      s_ready,
  input  logic                    err_clr,
  output logic [2:0]              err_status
);

  localparam int unsigned IdxW       = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
  localparam logic [7:0]  TimeoutCnt = 8'(TIMEOUT);

  logic [IdxW-1:0] dec_idx;
  logic            dec_mapped;

  soc_addr_decode #(
    .XLEN   (XLEN),
    .NSLAVES(NSLAVES),
    .SEL_LSB(SEL_LSB)
  ) u_decode (
    .addr_i  (mem_addr),
    .idx_o   (dec_idx),
    .mapped_o(dec_mapped)
  );

  bus_state_e         state_q, state_d;
  logic [NSLAVES-1:0] sel_q, sel_d;
  logic [XLEN-1:0]    addr_q, addr_d;
  logic [XLEN-1:0]    wdata_q, wdata_d;
  logic [3:0]         wmask_q, wmask_d;
  logic               rstrb_q, rstrb_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [XLEN-1:0]    rdata_q, rdata_d;
  logic [2:0]         err_q, err_d;

  logic            is_write, req;
  logic            slv_ready;
  logic [XLEN-1:0] slv_rdata;
  logic [2:0]      err_set;

  always_comb begin
    is_write  = |mem_wmask;
    req       = mem_rstrb | is_write;
    slv_ready = s_ready[idx_q];
    slv_rdata = s_rdata[32'(idx_q) * XLEN +: XLEN];
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rstrb_d = rstrb_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_set = '0;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (dec_mapped) begin
            sel_d          = '0;
            sel_d[dec_idx] = 1'b1;
            addr_d         = mem_addr;
            wdata_d        = mem_wdata;
            wmask_d        = mem_wmask;
            rstrb_d        = mem_rstrb & ~is_write;
            idx_d          = dec_idx;
            cnt_d          = '0;
            state_d        = StAccess;
          end else begin
            err_set[ErrUnmapped] = 1'b1;
            rdata_d              = ERR_WORD;
            state_d              = StResp;
          end
        end
      end
      StAccess: begin
        cnt_d = cnt_q + 8'd1;
        if (slv_ready) begin
          rdata_d = slv_rdata;
          sel_d   = '0;
          wmask_d = '0;
          rstrb_d = 1'b0;
          state_d = StResp;
        end else if (cnt_q + 8'd1 == TimeoutCnt) begin
          err_set[ErrTimeout] = 1'b1;
          rdata_d             = ERR_WORD;
          sel_d               = '0;
          wmask_d             = '0;
          rstrb_d             = 1'b0;
          state_d             = StResp;
        end
        if (req) err_set[ErrOverrun] = 1'b1;
      end
      StResp: begin
        state_d = StIdle;
        if (req) err_set[ErrOverrun] = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // A flag set in the same cycle as a clear survives.
    err_d = (err_clr ? 3'b000 : err_q) | err_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rstrb_q <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rstrb_q <= rstrb_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    mem_rdata  = rdata_q;
    mem_ready  = (state_q == StResp);
    mem_busy   = (state_q != StIdle);
    s_sel      = sel_q;
    s_addr     = addr_q;
    s_wdata    = wdata_q;
    s_wmask    = wmask_q;
    s_rstrb    = rstrb_q;
    err_status = err_q;
  end

endmodule

// File: tb/tb_soc_bus.sv
// Directed testbench for soc_bus: zero-wait read, waited write, unmapped,
// timeout, overrun, read/write precedence and asynchronous reset.
module tb_soc_bus;

  logic         clk;
  logic         rst;
  logic [31:0]  mem_addr;
  logic         mem_rstrb;
  logic [31:0]  mem_wdata;
  logic [3:0]   mem_wmask;
  logic [31:0]  mem_rdata;
  logic         mem_ready;
  logic         mem_busy;
  logic [3:0]   s_sel;
  logic [31:0]  s_addr;
  logic [31:0]  s_wdata;
  logic [3:0]   s_wmask;
  logic         s_rstrb;
  logic [127:0] s_rdata;
  logic [3:0]   s_ready;
  logic         err_clr;
  logic [2:0]   err_status;

  int n_checks = 0;
  int n_errors = 0;

  soc_bus dut (
    .clk       (clk),
    .rst       (rst),
    .mem_addr  (mem_addr),
    .mem_rstrb (mem_rstrb),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .mem_busy  (mem_busy),
    .s_sel     (s_sel),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_wmask   (s_wmask),
    .s_rstrb   (s_rstrb),
    .s_rdata   (s_rdata),
    .s_ready   (s_ready),
    .err_clr   (err_clr),
    .err_status(err_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge: the start of the next cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_rstrb = 1'b0;
    mem_wmask = 4'b0000;
    s_ready   = 4'b0000;
    err_clr   = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    mem_addr  = '0;
    mem_wdata = '0;
    s_rdata   = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    idle_inputs();
    #1;
    check_eq("rst_ready", 32'(mem_ready), 32'h0);
    check_eq("rst_busy", 32'(mem_busy), 32'h0);
    check_eq("rst_sel", 32'(s_sel), 32'h0);
    check_eq("rst_addr", s_addr, 32'h0);
    check_eq("rst_rdata", mem_rdata, 32'h0);
    check_eq("rst_err", 32'(err_status), 32'h0);
    step();
    step();
    rst = 1'b0;
    step();

    // Zero-wait read from slave 0
    mem_addr  = 32'h0000_0010;
    mem_rstrb = 1'b1;
    step();
    idle_inputs();
    check_eq("zw_sel", 32'(s_sel), 32'h1);
    check_eq("zw_rstrb", 32'(s_rstrb), 32'h1);
    check_eq("zw_addr", s_addr, 32'h0000_0010);
    check_eq("zw_ready_c1", 32'(mem_ready), 32'h0);
    check_eq("zw_busy", 32'(mem_busy), 32'h1);
    s_rdata[31:0] = 32'h1234_5678;
    s_ready       = 4'b0001;
    step();
    s_ready = 4'b0000;
    check_eq("zw_ready_c2", 32'(mem_ready), 32'h1);
    check_eq("zw_rdata", mem_rdata, 32'h1234_5678);
    check_eq("zw_desel", 32'(s_sel), 32'h0);
    check_eq("zw_err", 32'(err_status), 32'h0);
    step();
    check_eq("zw_ready_c3", 32'(mem_ready), 32'h0);
    check_eq("zw_idle", 32'(mem_busy), 32'h0);

    // Write to slave 2 with ready at cycle 4
    mem_addr  = 32'h0080_0004;
    mem_wdata = 32'hA5A5_0F0F;
    mem_wmask = 4'b0011;
    step();
    idle_inputs();
    check_eq("wr_sel", 32'(s_sel), 32'h4);
    check_eq("wr_wdata", s_wdata, 32'hA5A5_0F0F);
    check_eq("wr_rstrb", 32'(s_rstrb), 32'h0);
    for (int c = 1; c <= 4; c++) begin
      check_eq($sformatf("wr_wmask_c%0d", c), 32'(s_wmask), 32'h3);
      check_eq($sformatf("wr_noready_c%0d", c), 32'(mem_ready), 32'h0);
      if (c == 4) s_ready = 4'b0100;
      step();
    end
    s_ready = 4'b0000;
    check_eq("wr_ready_c5", 32'(mem_ready), 32'h1);
    check_eq("wr_wmask_clr", 32'(s_wmask), 32'h0);
    check_eq("wr_wdata_hold", s_wdata, 32'hA5A5_0F0F);
    step();

    // Unmapped read
    mem_addr  = 32'h0100_0000;
    mem_rstrb = 1'b1;
    step();
    idle_inputs();
    check_eq("um_ready_c1", 32'(mem_ready), 32'h1);
    check_eq("um_rdata", mem_rdata, 32'hDEAD_BEEF);
    check_eq("um_sel", 32'(s_sel), 32'h0);
    check_eq("um_err", 32'(err_status), 32'h2);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check_eq("um_err_clr", 32'(err_status), 32'h0);

    // Timeout on slave 1, with a stray ready from slave 3
    mem_addr  = 32'h0040_0000;
    mem_rstrb = 1'b1;
    step();
    idle_inputs();
    for (int c = 1; c <= 15; c++) begin
      check_eq($sformatf("to_sel_c%0d", c), 32'(s_sel), 32'h2);
      check_eq($sformatf("to_wait_c%0d", c), 32'(mem_ready), 32'h0);
      s_ready = (c == 5) ? 4'b1000 : 4'b0000;
      step();
    end
    s_ready = 4'b0000;
    check_eq("to_ready_c16", 32'(mem_ready), 32'h1);
    check_eq("to_rdata", mem_rdata, 32'hDEAD_BEEF);
    check_eq("to_err", 32'(err_status), 32'h1);
    check_eq("to_desel", 32'(s_sel), 32'h0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;

    // Overrun: second read while busy is dropped
    mem_addr  = 32'h0000_0020;
    mem_rstrb = 1'b1;
    step();
    check_eq("ov_sel_c1", 32'(s_sel), 32'h1);
    mem_addr = 32'h00C0_0000;
    step();
    idle_inputs();
    check_eq("ov_err", 32'(err_status), 32'h4);
    check_eq("ov_sel_c2", 32'(s_sel), 32'h1);
    check_eq("ov_addr", s_addr, 32'h0000_0020);
    s_rdata[31:0] = 32'hCAFE_F00D;
    s_ready       = 4'b0001;
    step();
    s_ready = 4'b0000;
    check_eq("ov_ready", 32'(mem_ready), 32'h1);
    check_eq("ov_rdata", mem_rdata, 32'hCAFE_F00D);
    step();
    check_eq("ov_no_second_sel", 32'(s_sel), 32'h0);
    check_eq("ov_no_second_busy", 32'(mem_busy), 32'h0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check_eq("ov_err_clr", 32'(err_status), 32'h0);

    // Read and write together: write wins
    mem_addr  = 32'h0000_0100;
    mem_wdata = 32'h0BAD_CAFE;
    mem_rstrb = 1'b1;
    mem_wmask = 4'b1111;
    step();
    idle_inputs();
    check_eq("pr_rstrb", 32'(s_rstrb), 32'h0);
    check_eq("pr_wmask", 32'(s_wmask), 32'hF);
    check_eq("pr_sel", 32'(s_sel), 32'h1);
    s_ready = 4'b0001;
    step();
    s_ready = 4'b0000;
    check_eq("pr_ready", 32'(mem_ready), 32'h1);
    step();

    // Asynchronous reset during a waiting access to slave 3
    mem_addr  = 32'h00C0_0008;
    mem_rstrb = 1'b1;
    step();
    idle_inputs();
    check_eq("ar_sel_c1", 32'(s_sel), 32'h8);
    step();
    #2;
    rst = 1'b1;
    #1;
    check_eq("ar_sel", 32'(s_sel), 32'h0);
    check_eq("ar_busy", 32'(mem_busy), 32'h0);
    check_eq("ar_ready", 32'(mem_ready), 32'h0);
    check_eq("ar_rstrb", 32'(s_rstrb), 32'h0);
    check_eq("ar_addr", s_addr, 32'h0);
    step();
    rst = 1'b0;
    step();
    check_eq("ar_no_ready", 32'(mem_ready), 32'h0);
    mem_addr  = 32'h00C0_0008;
    mem_rstrb = 1'b1;
    step();
    idle_inputs();
    check_eq("ar2_sel", 32'(s_sel), 32'h8);
    s_rdata[127:96] = 32'h7777_8888;
    s_ready         = 4'b1000;
    step();
    s_ready = 4'b0000;
    check_eq("ar2_ready", 32'(mem_ready), 32'h1);
    check_eq("ar2_rdata", mem_rdata, 32'h7777_8888);
    check_eq("ar2_err", 32'(err_status), 32'h0);
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
